// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - MEM-stage word access split into two half-word SRAM phases
module sram_word_ctrl #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_wr;
    logic [15:0]      wd_hi;
    logic             dq_oe;
    logic [15:0]      dq_out;
    logic [31:0]      off;
    logic             req;
    logic             last;
    logic             unused_off_bits;

    assign req   = wr_en | rd_en;
    assign last  = (cnt == CNT_LAST);
    assign off   = address - 32'(BASE_ADDR);
    assign ready = ~(req & (state != DONE));

    // Byte lane bits and anything above the SRAM window are dropped: word-aligned, wrapping.
    assign unused_off_bits = ^{off[31:ADDR_W], off[1:0]};

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            wd_hi     <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= LO;
                        cnt       <= '0;
                        op_wr     <= wr_en;
                        wd_hi     <= write_data[31:16];
                        dq_out    <= write_data[15:0];
                        dq_oe     <= wr_en;
                        SRAM_WE_N <= ~wr_en;
                        SRAM_ADDR <= {1'b0, off[ADDR_W-1:2], 1'b0};
                    end
                end
                LO: begin
                    if (last) begin
                        state        <= HI;
                        cnt          <= '0;
                        SRAM_ADDR[0] <= 1'b1;
                        dq_out       <= wd_hi;
                        if (!op_wr) read_data[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HI: begin
                    if (last) begin
                        state     <= DONE;
                        cnt       <= '0;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!op_wr) read_data[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb/tb_sram_word_ctrl.sv - table vectors, reset/corner sequences and random traffic vs word model
module tb_sram_word_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         sram_we_n;

    always #5 clk = ~clk;

    sram_word_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n)
    );

    // Off-chip SRAM: drives the bus whenever not being written.
    logic [15:0] sram [0:262143];
    assign sram_dq = sram_we_n ? sram[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem [int];
    logic [31:0] ref_rd = '0;

    logic [17:0] addr_seq [$];
    logic        we_seq   [$];
    logic [15:0] dq_seq   [$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          gap;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ha_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - 32'd1024;
        return int'((o % 32'h40000) / 4 * 2);
    endfunction

    function automatic logic [15:0] rm(input int h);
        return ref_mem.exists(h) ? ref_mem[h] : 16'h0000;
    endfunction

    function automatic void model_apply(input bit wr, input bit rd, input logic [31:0] a,
                                        input logic [31:0] d);
        int h;
        h = ha_of(a);
        if (wr) begin
            ref_mem[h]     = d[15:0];
            ref_mem[h + 1] = d[31:16];
        end else if (rd) begin
            ref_rd = {rm(h + 1), rm(h)};
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, output int freeze);
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        #1;
        addr_seq.delete(); we_seq.delete(); dq_seq.delete();
        freeze = 0;
        while (!ready && freeze < 40) begin
            freeze++;
            @(negedge clk);
            #1;
            if (!ready) begin
                addr_seq.push_back(sram_addr);
                we_seq.push_back(sram_we_n);
                dq_seq.push_back(sram_dq);
            end
        end
    endtask

    task automatic check_phases(input string tag, input bit wr, input logic [31:0] a,
                                input logic [31:0] d);
        int h;
        h = ha_of(a);
        chk({tag, "_phase_len"}, addr_seq.size(), 4);
        for (int i = 0; i < 4 && i < addr_seq.size(); i++) begin
            chk({tag, "_sram_addr"}, addr_seq[i], 32'(h + (i >= 2 ? 1 : 0)));
            chk({tag, "_we_n"}, we_seq[i], wr ? 32'd0 : 32'd1);
            if (wr) chk({tag, "_dq"}, dq_seq[i], (i >= 2) ? d[31:16] : d[15:0]);
        end
        if (wr) begin
            chk({tag, "_sram_lo"}, sram[h], d[15:0]);
            chk({tag, "_sram_hi"}, sram[h + 1], d[31:16]);
        end
    endtask

    initial begin
        int fz;
        logic [15:0] old7;

        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

        vecs.push_back('{1, 0, 32'd1024,   32'hDEADBEEF, 32'h00000000, 1});
        vecs.push_back('{0, 1, 32'd1024,   32'h00000000, 32'hDEADBEEF, 1});
        vecs.push_back('{1, 0, 32'd1028,   32'h12345678, 32'hDEADBEEF, 1});
        vecs.push_back('{0, 1, 32'd1028,   32'h00000000, 32'h12345678, 1});
        vecs.push_back('{1, 1, 32'd1032,   32'hCAFEF00D, 32'h12345678, 1});
        vecs.push_back('{0, 1, 32'd1032,   32'h00000000, 32'hCAFEF00D, 1});
        vecs.push_back('{0, 1, 32'd1026,   32'h00000000, 32'hDEADBEEF, 1});
        vecs.push_back('{1, 0, 32'd1023,   32'h0BADCAFE, 32'hDEADBEEF, 1});
        vecs.push_back('{0, 1, 32'd263164, 32'h00000000, 32'h0BADCAFE, 1});
        vecs.push_back('{0, 1, 32'd263168, 32'h00000000, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 0, 32'd1040,   32'h11112222, 32'hDEADBEEF, 0});
        vecs.push_back('{0, 1, 32'd1040,   32'h00000000, 32'h11112222, 1});

        #1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_we_n", sram_we_n, 1);
        chk("reset_sram_addr", sram_addr, 0);
        chk("reset_read_data", read_data, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, fz);
            model_apply(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_freeze", i), fz, 5);
            chk($sformatf("vec%0d_ready_done", i), ready, 1);
            chk($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_model_rd", i), read_data, ref_rd);
            check_phases($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data);
            idle(vecs[i].gap);
        end

        // Request dropped after the first cycle still completes the store.
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1044; write_data = 32'h76543210;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("drop_ready", ready, 1);
        repeat (5) @(negedge clk);
        model_apply(1, 0, 32'd1044, 32'h76543210);
        chk("drop_sram_lo", sram[10], 16'h3210);
        chk("drop_sram_hi", sram[11], 16'h7654);

        // Reset while the high half of a store is on the pins.
        old7 = rm(7);
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hA5A55A5A;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mid_we_in_hi", sram_we_n, 0);
        chk("rst_mid_addr_in_hi", sram_addr, 7);
        rst = 1'b0;
        #1;
        chk("rst_mid_we_n", sram_we_n, 1);
        chk("rst_mid_sram_addr", sram_addr, 0);
        chk("rst_mid_read_data", read_data, 0);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_sram6", sram[6], 16'h5A5A);
        chk("rst_mid_sram7_old", sram[7], old7);
        @(negedge clk);
        rst = 1'b1;
        ref_mem[6] = 16'h5A5A;
        ref_rd = '0;
        run_txn(0, 1, 32'd1036, 32'h0, fz);
        model_apply(0, 1, 32'd1036, 32'h0);
        chk("rst_recover_freeze", fz, 5);
        chk("rst_recover_read", read_data, {old7, 16'h5A5A});
        idle(1);

        for (int n = 0; n < 40; n++) begin
            int op;
            bit w, r;
            logic [31:0] a, d;
            op = $urandom_range(0, 2);
            w = (op != 1);
            r = (op != 0);
            a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            d = $urandom;
            run_txn(w, r, a, d, fz);
            model_apply(w, r, a, d);
            chk($sformatf("rnd%0d_freeze", n), fz, 5);
            chk($sformatf("rnd%0d_read_data", n), read_data, ref_rd);
            if (w) begin
                chk($sformatf("rnd%0d_sram_lo", n), sram[ha_of(a)], rm(ha_of(a)));
                chk($sformatf("rnd%0d_sram_hi", n), sram[ha_of(a) + 1], rm(ha_of(a) + 1));
            end
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
